// File: rtl/dogx_offset_cal_sequencer.sv
// DOGX offset-calibration sequencer: settles, averages 2^LOG2_AVG samples to
// estimate the converter DC offset, then emits offset-corrected, saturated
// samples at the 3 MHz strobe rate.
module dogx_offset_cal_sequencer #(
  parameter int SETTLE_SAMPLES = 16,
  parameter int LOG2_AVG       = 6,
  parameter int AUTO_CAL       = 1
) (
  input  logic        CLK_24M,
  input  logic        reset,
  input  logic        enable_sampling_3M,
  input  logic [10:0] converter_output,
  input  logic        alpha_req,
  input  logic        start_cal,
  output logic        alpha_to_converter,
  output logic [10:0] offset,
  output logic [10:0] corrected_output,
  output logic        output_valid,
  output logic        cal_busy,
  output logic        cal_done
);

  localparam int ACC_W = 11 + LOG2_AVG;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCUM,
    S_RUN
  } state_e;

  state_e                    state_q, state_d;
  logic [7:0]                settle_cnt_q, settle_cnt_d;
  logic [LOG2_AVG-1:0]       avg_cnt_q, avg_cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [10:0]               offset_q, offset_d;
  logic [10:0]               corr_q, corr_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [11:0]        diff;
  logic [10:0]               sat;

  // Datapath: running sum, corrected difference and its 11-bit clamp.
  always_comb begin
    acc_sum = acc_q + {{LOG2_AVG{converter_output[10]}}, converter_output};
    diff    = {converter_output[10], converter_output} - {offset_q[10], offset_q};
    // Overflow out of 11 bits shows up as the top two bits disagreeing.
    if (diff[11] != diff[10]) sat = diff[11] ? 11'h400 : 11'h3FF;
    else                      sat = diff[10:0];
  end

  // Next-state and register-input logic for the calibration FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    avg_cnt_d    = avg_cnt_q;
    acc_d        = acc_q;
    offset_d     = offset_q;
    corr_d       = corr_q;
    valid_d      = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if ((AUTO_CAL != 0) || start_cal) begin
          state_d      = S_SETTLE;
          settle_cnt_d = '0;
        end
      end
      S_SETTLE: begin
        if (enable_sampling_3M) begin
          if (settle_cnt_q == 8'(SETTLE_SAMPLES - 1)) begin
            state_d   = S_ACCUM;
            acc_d     = '0;
            avg_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end
      end
      S_ACCUM: begin
        if (enable_sampling_3M) begin
          acc_d = acc_sum;
          if (avg_cnt_q == '1) begin
            // Taking the slice above the fraction bits is an arithmetic
            // shift, i.e. rounding toward negative infinity.
            offset_d = acc_sum[LOG2_AVG +: 11];
            done_d   = 1'b1;
            state_d  = S_RUN;
          end else begin
            avg_cnt_d = avg_cnt_q + LOG2_AVG'(1);
          end
        end
      end
      S_RUN: begin
        if (start_cal) begin
          state_d      = S_SETTLE;
          settle_cnt_d = '0;
        end else if (enable_sampling_3M) begin
          corr_d  = sat;
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_ACCUM);
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      avg_cnt_q    <= '0;
      acc_q        <= '0;
      offset_q     <= '0;
      corr_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      avg_cnt_q    <= avg_cnt_d;
      acc_q        <= acc_d;
      offset_q     <= offset_d;
      corr_q       <= corr_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign alpha_to_converter = busy_q ? 1'b0 : alpha_req;
  assign offset             = offset_q;
  assign corrected_output   = corr_q;
  assign output_valid       = valid_q;
  assign cal_busy           = busy_q;
  assign cal_done           = done_q;

endmodule

// File: tb/tb_dogx_offset_cal_sequencer.sv
// Bench for dogx_offset_cal_sequencer: a behavioural model predicts each
// cal_done/output_valid event into queues; a monitor on the falling edge
// pops and compares, and tracks busy/alpha/offset/output levels every cycle.
module tb_dogx_offset_cal_sequencer;

  localparam int SETTLE = 4;
  localparam int L      = 4;
  localparam int N      = 1 << L;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stb = 1'b0;
  logic [10:0] conv = '0;
  logic        alpha_req = 1'b1;
  logic        start_cal = 1'b0;
  logic        alpha_to_converter;
  logic [10:0] offset;
  logic [10:0] corrected_output;
  logic        output_valid;
  logic        cal_busy;
  logic        cal_done;

  dogx_offset_cal_sequencer #(
    .SETTLE_SAMPLES(SETTLE),
    .LOG2_AVG      (L),
    .AUTO_CAL      (1)
  ) dut (
    .CLK_24M           (clk),
    .reset             (rst_n),
    .enable_sampling_3M(stb),
    .converter_output  (conv),
    .alpha_req         (alpha_req),
    .start_cal         (start_cal),
    .alpha_to_converter(alpha_to_converter),
    .offset            (offset),
    .corrected_output  (corrected_output),
    .output_valid      (output_valid),
    .cal_busy          (cal_busy),
    .cal_done          (cal_done)
  );

  always #5 clk = ~clk;

  // Behavioural model: idle, calibrating (settle+average) or running.
  typedef enum int {M_IDLE, M_CAL, M_RUN} mmode_e;
  mmode_e mmode = M_IDLE;
  int     cal_n = 0;       // strobes seen in the current calibration
  int     cal_sum = 0;     // sum of the averaged samples
  int     exp_offset = 0;
  int     exp_corr = 0;
  bit     exp_busy = 1'b0;
  int     valid_q[$];
  int     done_q[$];

  int     checks = 0;
  int     failures = 0;
  int     phase = 0;
  int     pat_cal = 0;     // 0 constant, 1 eight -1 then eight -2, 2 random
  int     cal_val = 0;
  bit     run_rand = 1'b0;
  int     run_val = 0;
  bit     alpha_rand = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rand11();
    int r;
    r = int'($urandom_range(0, 2047));
    return (r >= 1024) ? r - 2048 : r;
  endfunction

  function automatic int sat11(input int v);
    if (v > 1023)  return 1023;
    if (v < -1024) return -1024;
    return v;
  endfunction

  function automatic int floor_div(input int s, input int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  function automatic int cal_sample(input int idx);
    case (pat_cal)
      0:       return cal_val;
      1:       return (idx < 8) ? -1 : -2;
      default: return rand11();
    endcase
  endfunction

  // Predict what the coming rising edge does with the inputs now applied.
  task automatic model_edge();
    int xs;
    if (!rst_n) return;
    xs = int'($signed(conv));
    case (mmode)
      M_IDLE: begin
        mmode = M_CAL; cal_n = 0; cal_sum = 0;
      end
      M_CAL: begin
        if (stb) begin
          cal_n++;
          if (cal_n > SETTLE) cal_sum += xs;
          if (cal_n == SETTLE + N) begin
            exp_offset = floor_div(cal_sum, N);
            done_q.push_back(exp_offset);
            mmode = M_RUN;
          end
        end
      end
      default: begin
        if (start_cal) begin
          mmode = M_CAL; cal_n = 0; cal_sum = 0;
        end else if (stb) begin
          exp_corr = sat11(xs - exp_offset);
          valid_q.push_back(exp_corr);
        end
      end
    endcase
    exp_busy = (mmode == M_CAL);
  endtask

  // One clock of stimulus: strobe every 8th clock, sample from the pattern.
  task automatic step(input bit sc);
    int x;
    bit s;
    @(negedge clk); #1;
    s = (phase == 7);
    phase = (phase + 1) % 8;
    if (mmode == M_CAL && cal_n >= SETTLE) x = cal_sample(cal_n - SETTLE);
    else if (mmode == M_RUN)               x = run_rand ? rand11() : run_val;
    else                                   x = rand11();
    stb       = s;
    conv      = x[10:0];
    start_cal = sc;
    alpha_req = alpha_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    model_edge();
  endtask

  task automatic wait_run();
    for (int i = 0; i < 400 && mmode != M_RUN; i++) step(1'b0);
  endtask

  task automatic run_strobes(input int k);
    repeat (8 * k) step(1'b0);
  endtask

  task automatic restart(input bit on_strobe);
    if (on_strobe) while (phase != 7) step(1'b0);
    step(1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_offset"}, $signed(offset), 0);
    check({tag, "_corr"}, $signed(corrected_output), 0);
    check({tag, "_valid"}, output_valid, 0);
    check({tag, "_busy"}, cal_busy, 0);
    check({tag, "_done"}, cal_done, 0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk); #1;
    rst_n = 1'b0;
    mmode = M_IDLE; cal_n = 0; cal_sum = 0;
    exp_offset = 0; exp_corr = 0; exp_busy = 1'b0;
    valid_q.delete(); done_q.delete();
    #1;
    check_zero(tag);
    repeat (3) step(1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // Monitor: level checks every cycle, event checks against the queues.
  always @(negedge clk) begin
    int e;
    check("busy", cal_busy, exp_busy);
    check("alpha", alpha_to_converter, exp_busy ? 1'b0 : alpha_req);
    check("offset_level", $signed(offset), exp_offset);
    check("corr_level", $signed(corrected_output), exp_corr);
    if (valid_q.size() != 0) begin
      e = valid_q.pop_front();
      check("valid_pulse", output_valid, 1);
      check("corr_value", $signed(corrected_output), e);
    end else begin
      check("no_valid", output_valid, 0);
    end
    if (done_q.size() != 0) begin
      e = done_q.pop_front();
      check("done_pulse", cal_done, 1);
      check("done_offset", $signed(offset), e);
    end else begin
      check("no_done", cal_done, 0);
    end
  end

  initial begin
    // Power-on reset and automatic calibration on a constant 5.
    #1 rst_n = 1'b0;
    #2 check_zero("por");
    repeat (2) step(1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    pat_cal = 0; cal_val = 5; run_rand = 1'b0; run_val = 5;
    wait_run();
    step(1'b0);
    check("auto_offset", $signed(offset), 5);
    run_strobes(6);
    check("auto_corr", $signed(corrected_output), 0);

    // Floor rounding of a negative average; restart lands on a strobe.
    pat_cal = 1; run_val = 0;
    restart(1'b1);
    wait_run();
    step(1'b0);
    check("neg_offset", $signed(offset), -2);
    run_strobes(4);
    check("neg_corr", $signed(corrected_output), 2);

    // Positive and negative saturation.
    pat_cal = 0; cal_val = -100; run_val = 1000;
    restart(1'b0);
    wait_run();
    run_strobes(4);
    check("sat_hi", $signed(corrected_output), 1023);
    cal_val = 100; run_val = -1000;
    restart(1'b0);
    wait_run();
    run_strobes(4);
    check("sat_lo", $signed(corrected_output), -1024);

    // start_cal while averaging is ignored: only one cal_done follows.
    pat_cal = 2; run_rand = 1'b1; alpha_rand = 1'b1;
    restart(1'b0);
    while (!(mmode == M_CAL && cal_n == SETTLE + 5)) step(1'b0);
    step(1'b1);
    step(1'b1);
    wait_run();
    run_strobes(10);

    // Reset while averaging, then a clean calibration on a constant 7.
    restart(1'b0);
    while (!(mmode == M_CAL && cal_n == SETTLE + 7)) step(1'b0);
    apply_reset("mid_accum");
    pat_cal = 0; cal_val = 7;
    wait_run();
    step(1'b0);
    check("post_reset_offset", $signed(offset), 7);
    run_strobes(8);

    repeat (3) step(1'b0);
    check("queues_drained", valid_q.size() + done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dogx_offset_cal_sequencer.md
# dogx_offset_cal_sequencer

Startup and on-demand offset-calibration sequencer for the DOGX digital converter output. It sits directly after the converter at the 3 MHz sample rate. During calibration it forces the converter onto the HSNR channel, waits for the datapath to settle, and averages a programmable number of samples to estimate the DC offset. Afterwards it delivers offset-corrected, saturated samples with a valid strobe.

## Interface
Parameters:
- `SETTLE_SAMPLES`, default 16: number of 3 MHz strobes discarded before accumulation (1..255).
- `LOG2_AVG`, default 6: log2 of the number of samples averaged (1..10).
- `AUTO_CAL`, default 1: when 1, calibration starts automatically after reset release.

Ports:
- `CLK_24M`, in, 1: system clock. One clock domain.
- `reset`, in, 1: asynchronous, active-low reset.
- `enable_sampling_3M`, in, 1: one-cycle sample strobe, one every 8 clocks, from the clockgen.
- `converter_output`, in, 11: signed two's-complement converter sample.
- `alpha_req`, in, 1: alpha select requested by the system.
- `start_cal`, in, 1: level, sampled each clock. Requests a calibration.
- `alpha_to_converter`, out, 1: alpha select driven to the converter `alpha_in`.
- `offset`, out, 11: signed offset estimate.
- `corrected_output`, out, 11: signed corrected sample.
- `output_valid`, out, 1: one-cycle pulse when `corrected_output` is new.
- `cal_busy`, out, 1: high in SETTLE and ACCUM.
- `cal_done`, out, 1: one-cycle pulse at calibration completion.

## Operation
- The FSM has four states: IDLE, SETTLE, ACCUM, RUN. The reset state is IDLE.
- Reset values are 0 for all outputs and for the internal counters and accumulator.
- IDLE:
  - If `AUTO_CAL=1`, go to SETTLE on the first clock after reset deassertion.
  - Otherwise go to SETTLE when `start_cal=1`.
  - Sample strobes are ignored.
- SETTLE:
  - Count strobes. On the `SETTLE_SAMPLES`-th strobe, clear the accumulator and sample counter, then go to ACCUM.
  - That strobe's sample is not accumulated.
- ACCUM:
  - On each strobe, `acc <= acc + sign_extend(converter_output)`. The accumulator is 11+`LOG2_AVG` bits, so it cannot overflow.
  - On the 2^`LOG2_AVG`-th strobe, include that sample, then:
    - `offset <= (acc_final) >>> LOG2_AVG`. This is an arithmetic shift, rounding toward negative infinity.
    - Pulse `cal_done` for one cycle.
    - Go to RUN.
- RUN:
  - On each strobe, `corrected_output <= sat11(converter_output - offset)`.
  - The difference is computed at 12 bits signed and clamped to [-1024, +1023].
  - `start_cal=1` goes to SETTLE. `offset` holds its old value until the new calibration completes.
- `start_cal` is ignored in SETTLE and ACCUM. Calibration cannot be restarted while busy.
- `alpha_to_converter` is combinational: 0 when `cal_busy`, else `alpha_req`.
- `corrected_output` holds its last value outside RUN. `output_valid` is 0 outside RUN.
- `cal_busy` is registered and equals (state==SETTLE || state==ACCUM).

## Timing
- State transitions take effect on the clock edge where the condition is sampled.
- `cal_busy` rises 1 clock after the `start_cal` sample, or 1 clock after reset release when `AUTO_CAL=1`.
- Calibration duration is `SETTLE_SAMPLES`+2^`LOG2_AVG` strobes, i.e. ≈8×(that) clocks, depending on strobe phase.
- `cal_done` pulses, `cal_busy` falls and `offset` updates on the same edge. That edge is the one sampling the last ACCUM strobe.
- RUN latency: `corrected_output` updates on the strobe edge. `output_valid` is high for exactly the next clock cycle. The output is registered, with 1 clock from strobe to valid data.
- Simultaneous events:
  - A strobe and the edge that leaves RUN for SETTLE in the same cycle: the sample is not processed, and no `output_valid` is produced.
  - A strobe on the cycle SETTLE is entered from IDLE or RUN is not counted.
- Asynchronous reset mid-operation, in any state, returns to IDLE with all outputs 0. With `AUTO_CAL=1` a fresh calibration follows.

## Test plan
- Reset and auto-cal: `AUTO_CAL=1`, `SETTLE_SAMPLES=4`, `LOG2_AVG=4`, constant input 5.
  - `cal_busy` rises 1 clock after reset release.
  - `cal_done` pulses after 20 strobes, with `offset`=5.
  - Subsequent `corrected_output`=0, with `output_valid` 1 clock after each strobe.
- Negative truncation: with `LOG2_AVG=4`, accumulate 8×(-1) and 8×(-2). The sum is -24, giving `offset`=-2. Input 0 then gives `corrected_output`=+2.
- Saturation:
  - With `offset`=-100, input +1000 → 1023.
  - With `offset`=+100, input -1000 → -1024.
- Alpha override:
  - Hold `alpha_req`=1. `alpha_to_converter`=0 throughout SETTLE and ACCUM, and 1 in IDLE and RUN.
- Restart rules, with `AUTO_CAL=0`:
  - Pulse `start_cal` in IDLE → calibration runs.
  - Pulse `start_cal` again mid-ACCUM → ignored; a single `cal_done`.
  - Pulse `start_cal` in RUN → recalibration. The old `offset` holds until the new `cal_done`.
- Reset mid-ACCUM: assert `reset` during ACCUM.
  - All outputs are 0 immediately.
  - The state returns to IDLE, and no `cal_done` is produced.
  - The accumulator is cleared, so the next calibration yields the correct offset.
